// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: latches a packed digit vector on load,
// scans one digit per refresh slot and drives registered active-low segment/anode outputs.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int HEX_MODE   = 0,
    parameter int BLANK_LEAD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_digits;
    logic [DIGITS-1:0]   r_dp;

    logic                w_tick;
    logic [3:0]          w_code;
    logic                w_dpSel;
    logic                w_blank;
    logic                w_zeroAcc;
    logic [DIGITS-1:0]   w_blankVec;
    logic [DIGITS-1:0]   w_anSel;
    logic [6:0]          w_segCode;

    assign w_tick = (r_presc == PRESC_MAX);

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] glyph;
        case (code)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
            4'hB:    glyph = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
            4'hC:    glyph = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
            4'hD:    glyph = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
            4'hE:    glyph = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
            default: glyph = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
        endcase
        return glyph;
    endfunction

    // Scan timing keeps running while the display is disabled so re-enable lands on the live slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_idx      <= '0;
            frame_done <= 1'b0;
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            frame_done <= w_tick && (r_idx == IDX_MAX);
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_dp     <= '0;
        end else if (load) begin
            r_digits <= din;
            r_dp     <= dp_in;
        end
    end

    // A digit is leading-zero blank when it and every more significant digit are zero.
    always_comb begin
        w_code     = 4'd0;
        w_dpSel    = 1'b0;
        w_blank    = 1'b0;
        w_anSel    = '1;
        w_zeroAcc  = 1'b1;
        w_blankVec = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zeroAcc     = w_zeroAcc & (r_digits[4*k +: 4] == 4'd0);
            w_blankVec[k] = (BLANK_LEAD != 0) && (k != 0) && w_zeroAcc;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_code     = r_digits[4*k +: 4];
                w_dpSel    = r_dp[k];
                w_blank    = w_blankVec[k];
                w_anSel[k] = 1'b0;
            end
        end
        w_segCode = w_blank ? 7'b1111111 : decode(w_code);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= '1;
        end else if (enable) begin
            seg <= w_segCode;
            dp  <= ~w_dpSel;
            an  <= w_anSel;
        end else begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a decimal and a hex-mode instance share stimulus and are
// compared every cycle against a time-based reference model of the scan.
module tb_seg7_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = DIGITS * CLK_DIV;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        enable;
    logic [15:0] din;
    logic [3:0]  dpIn;

    logic [6:0]  seg, segHex;
    logic        dp, dpHex;
    logic [3:0]  an, anHex;
    logic        frameDone, frameDoneHex;

    int          compared;
    int          mismatched;

    int          mEdges;
    logic [15:0] mDigits;
    logic [3:0]  mDp;
    logic [6:0]  expSeg, expSegHex;
    logic        expDp;
    logic [3:0]  expAn;
    logic        expFd;

    seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_MODE(0), .BLANK_LEAD(1)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dpIn), .enable(enable),
        .seg(seg), .dp(dp), .an(an), .frame_done(frameDone)
    );

    seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HEX_MODE(1), .BLANK_LEAD(1)) dutHex (
        .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dpIn), .enable(enable),
        .seg(segHex), .dp(dpHex), .an(anHex), .frame_done(frameDoneHex)
    );

    always #5 clk = ~clk;

    // After n edges since reset release the outputs show the slot (n-1)/CLK_DIV mod DIGITS,
    // using the digits latched before this edge; a frame ends on every FRAME-th edge.
    always @(posedge clk or posedge reset) begin : refModel
        int          n;
        int          slot;
        logic [3:0]  code;
        logic        blankDigit;
        if (reset) begin
            mEdges    <= 0;
            mDigits   <= '0;
            mDp       <= '0;
            expSeg    <= 7'h7F;
            expSegHex <= 7'h7F;
            expDp     <= 1'b1;
            expAn     <= 4'hF;
            expFd     <= 1'b0;
        end else begin
            n          = mEdges + 1;
            slot       = ((n - 1) / CLK_DIV) % DIGITS;
            code       = mDigits[4*slot +: 4];
            blankDigit = (slot != 0) && ((mDigits >> (4 * slot)) == 16'd0);
            mEdges    <= n;
            expFd     <= ((n % FRAME) == 0);
            if (enable) begin
                expAn       <= 4'hF & ~(4'b0001 << slot);
                expDp       <= ~mDp[slot];
                expSeg      <= (blankDigit || code > 4'd9) ? 7'h7F : DEC[code];
                expSegHex   <= blankDigit ? 7'h7F : DEC[code];
            end else begin
                expAn     <= 4'hF;
                expDp     <= 1'b1;
                expSeg    <= 7'h7F;
                expSegHex <= 7'h7F;
            end
            if (load) begin
                mDigits <= din;
                mDp     <= dpIn;
            end
        end
    end

    task automatic checkVec(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVec({tag, ".seg"},    {1'b0, seg},    {1'b0, expSeg});
        checkVec({tag, ".segHex"}, {1'b0, segHex}, {1'b0, expSegHex});
        checkVec({tag, ".dp"},     {7'b0, dp},     {7'b0, expDp});
        checkVec({tag, ".an"},     {4'b0, an},     {4'b0, expAn});
        checkVec({tag, ".anHex"},  {4'b0, anHex},  {4'b0, expAn});
        checkVec({tag, ".fd"},     {7'b0, frameDone},    {7'b0, expFd});
        checkVec({tag, ".fdHex"},  {7'b0, frameDoneHex}, {7'b0, expFd});
    endtask

    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] dpv, input logic en);
        load   = ld;
        din    = d;
        dpIn   = dpv;
        enable = en;
    endtask

    task automatic stepCycles(input int cycles, input string tag);
        repeat (cycles) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int   fdCount;
        bit   found;
        logic [15:0] rnd;

        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'h0, 1'b1);

        #12;
        checkOutput("reset_hold");
        checkVec("reset_an", {4'b0, an}, 8'h0F);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] scan of all-zero display");
        @(negedge clk);
        checkOutput("first_slot");
        checkVec("first_an",  {4'b0, an}, 8'b0000_1110);
        checkVec("first_seg", {1'b0, seg}, 8'b0100_0000);
        stepCycles(16, "scan_zero");
        fdCount = 0;
        repeat (32) begin
            @(negedge clk);
            checkOutput("frame_rate");
            fdCount += int'(frameDone);
        end
        checkVec("frame_count", 8'(fdCount), 8'd2);

        $display("[TB] leading-zero blanking and decimal point");
        applyStimulus(1'b1, 16'h0907, 4'b0010, 1'b1);
        stepCycles(1, "load_0907");
        load = 1'b0;
        stepCycles(20, "show_0907");

        $display("[TB] hex codes");
        applyStimulus(1'b1, 16'h00A5, 4'b0000, 1'b1);
        stepCycles(1, "load_00A5");
        load = 1'b0;
        stepCycles(20, "show_00A5");

        $display("[TB] load coinciding with frame wrap");
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (((mEdges + 1) % FRAME) == 0) found = 1'b1;
            else stepCycles(1, "seek_wrap");
        end
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL seek_wrap observed=not_found expected=found");
        end else begin
            applyStimulus(1'b1, 16'h0004, 4'b0000, 1'b1);
            @(negedge clk);
            checkOutput("wrap_edge");
            checkVec("wrap_fd", {7'b0, frameDone}, 8'd1);
            load = 1'b0;
            @(negedge clk);
            checkOutput("wrap_next");
            checkVec("wrap_an",  {4'b0, an}, 8'b0000_1110);
            checkVec("wrap_seg", {1'b0, seg}, 8'b0001_1001);
        end
        stepCycles(8, "after_wrap");

        $display("[TB] display disable mid-scan");
        applyStimulus(1'b0, 16'h4321, 4'b0000, 1'b1);
        load = 1'b1;
        stepCycles(1, "load_4321");
        load = 1'b0;
        stepCycles(5, "pre_disable");
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("disabled");
            checkVec("disabled_an", {4'b0, an}, 8'h0F);
        end
        enable = 1'b1;
        stepCycles(12, "reenabled");

        $display("[TB] randomized traffic");
        repeat (300) begin
            rnd = '0;
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(0, 1) == 0) rnd[4*k +: 4] = 4'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 3) == 0, rnd, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 7) != 0);
            stepCycles(1, "random");
        end

        $display("[TB] asynchronous reset mid-slot");
        applyStimulus(1'b1, 16'h1234, 4'b1111, 1'b1);
        stepCycles(1, "load_1234");
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if ((mEdges % FRAME) == 2 * CLK_DIV + 1) found = 1'b1;
            else stepCycles(1, "seek_idx2");
        end
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL seek_idx2 observed=not_found expected=found");
        end
        checkVec("pre_reset_an", {4'b0, an}, 8'b0000_1011);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset");
        checkVec("async_an",  {4'b0, an}, 8'h0F);
        checkVec("async_seg", {1'b0, seg}, 8'h7F);
        @(negedge clk);
        checkOutput("reset_held");
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset");
        checkVec("post_reset_an",  {4'b0, an}, 8'b0000_1110);
        checkVec("post_reset_seg", {1'b0, seg}, 8'b0100_0000);
        stepCycles(20, "post_reset_scan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
